// File: rtl/systolic_output_collector.sv
// systolic_output_collector: de-skews the bottom-row partial sums of a
// weight-stationary systolic array into aligned rows, buffers them in a
// small row FIFO and serializes each row one element per cycle onto a
// valid/ready stream.
module systolic_output_collector #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COLS  = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                              CLK,
    input  logic                              ASYNC_RST,
    input  logic                              SYNC_RST,
    input  logic [COLS*(2*WIDTH+1)-1:0]       PSUM_IN,
    input  logic [COLS-1:0]                   PSUM_VALID_IN,
    output logic [2*WIDTH:0]                  OUT_DATA,
    output logic [$clog2(COLS)-1:0]           OUT_COL,
    output logic                              OUT_LAST,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic                              FULL,
    output logic                              OVERFLOW,
    output logic                              SKEW_ERR
);

    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned ROW_W = COLS * ACC_W;
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Aligned row as seen after the de-skew stages
    logic [ROW_W-1:0]  al_row;
    logic [COLS-1:0]   al_valid;

    // Row FIFO state
    logic [ROW_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ROW_W-1:0]  head;
    logic              fifo_empty;

    // Serializer state
    state_t            state;
    logic [ROW_W-1:0]  row_q;
    logic              at_last;

    // Row-level handshake between de-skew, FIFO and serializer
    logic              all_v;
    logic              any_v;
    logic              pop_c;
    logic              wr_c;
    logic              drop_c;
    logic              skew_c;

    // Column c is delayed COLS-1-c cycles so that all columns of a row line up
    for (genvar c = 0; c < int'(COLS); c++) begin : g_col
        localparam int unsigned STAGES = COLS - 1 - c;

        if (STAGES == 0) begin : g_pass
            assign al_row[c*ACC_W +: ACC_W] = PSUM_IN[c*ACC_W +: ACC_W];
            assign al_valid[c]              = PSUM_VALID_IN[c];
        end else begin : g_dly
            logic [ACC_W-1:0]  d_q [STAGES];
            logic [STAGES-1:0] v_q;

            // Shift register carrying this column's data and valid
            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) begin
                    for (int i = 0; i < int'(STAGES); i++) begin
                        d_q[i] <= '0;
                    end
                    v_q <= '0;
                end else if (SYNC_RST) begin
                    for (int i = 0; i < int'(STAGES); i++) begin
                        d_q[i] <= '0;
                    end
                    v_q <= '0;
                end else begin
                    d_q[0] <= PSUM_IN[c*ACC_W +: ACC_W];
                    v_q[0] <= PSUM_VALID_IN[c];
                    for (int i = 1; i < int'(STAGES); i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            assign al_row[c*ACC_W +: ACC_W] = d_q[STAGES-1];
            assign al_valid[c]              = v_q[STAGES-1];
        end
    end

    assign fifo_empty = (count == '0);
    assign FULL       = (count == CNT_W'(DEPTH));
    assign head       = mem[rd_ptr];
    assign at_last    = (OUT_COL == COL_W'(COLS - 1));

    // Row classification, FIFO push/pop decisions
    always_comb begin
        all_v  = &al_valid;
        any_v  = |al_valid;
        pop_c  = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE) begin
                pop_c = 1'b1;
            end else if (OUT_READY && at_last) begin
                pop_c = 1'b1;
            end
        end
        wr_c   = all_v && (!FULL || pop_c);
        drop_c = all_v && FULL && !pop_c;
        skew_c = any_v && !all_v;
    end

    // Row storage; contents need no reset since pointers define occupancy
    always_ff @(posedge CLK) begin
        if (wr_c) begin
            mem[wr_ptr] <= al_row;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (SYNC_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            OVERFLOW <= 1'b0;
            SKEW_ERR <= 1'b0;
        end else if (SYNC_RST) begin
            OVERFLOW <= 1'b0;
            SKEW_ERR <= 1'b0;
        end else begin
            if (drop_c) begin
                OVERFLOW <= 1'b1;
            end
            if (skew_c) begin
                SKEW_ERR <= 1'b1;
            end
        end
    end

    // Serializer: the row register shifts right so the next element is always at the bottom
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state     <= S_IDLE;
            row_q     <= '0;
            OUT_DATA  <= '0;
            OUT_COL   <= '0;
            OUT_LAST  <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (SYNC_RST) begin
            state     <= S_IDLE;
            row_q     <= '0;
            OUT_DATA  <= '0;
            OUT_COL   <= '0;
            OUT_LAST  <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state     <= S_SEND;
                        row_q     <= head;
                        OUT_DATA  <= head[ACC_W-1:0];
                        OUT_COL   <= '0;
                        OUT_LAST  <= 1'b0;
                        OUT_VALID <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (OUT_READY) begin
                        if (!at_last) begin
                            row_q    <= row_q >> ACC_W;
                            OUT_DATA <= row_q[ACC_W +: ACC_W];
                            OUT_COL  <= OUT_COL + COL_W'(1);
                            OUT_LAST <= (OUT_COL == COL_W'(COLS - 2));
                        end else if (!fifo_empty) begin
                            row_q    <= head;
                            OUT_DATA <= head[ACC_W-1:0];
                            OUT_COL  <= '0;
                            OUT_LAST <= 1'b0;
                        end else begin
                            state     <= S_IDLE;
                            OUT_DATA  <= '0;
                            OUT_COL   <= '0;
                            OUT_LAST  <= 1'b0;
                            OUT_VALID <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
